// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one bitwise AND/OR gate unit between NREQ requesters.
// Optional macro GATE_ARB_XOR_EN adds XOR/XNOR for opcodes 1x; otherwise they report res_err.
module gate_op_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 1,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   op_sel,
  input  logic [W*NREQ-1:0]   a_in,
  input  logic [W*NREQ-1:0]   b_in,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [W-1:0]        res_data,
  output logic [IDW-1:0]      res_id,
  output logic                res_err
);

  typedef enum logic [1:0] {IDLE, GRANT, EXEC, RESP} state_t;

  state_t              state, state_nxt;
  logic [IDW-1:0]      ptr, win, pick;
  logic                found, load_win;
  logic [2*NREQ-1:0]   req_dbl;
  logic [NREQ-1:0]     rot;
  logic [1:0]          op_w, op_p0;
  logic [W-1:0]        a_w, b_w, a_p0, b_p0;
  logic [W:0]          gate_res;

  function automatic logic [IDW-1:0] mod_add(input logic [IDW-1:0] x, input logic [IDW-1:0] y);
    logic [IDW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
    return s[IDW-1:0];
  endfunction

  // Returns {err, data}.
  function automatic logic [W:0] gate_eval(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0] r;
    case (op)
      2'b00:   r = {1'b0, a & b};
      2'b01:   r = {1'b0, a | b};
`ifdef GATE_ARB_XOR_EN
      2'b10:   r = {1'b0, a ^ b};
      default: r = {1'b0, ~(a ^ b)};
`else
      default: r = {1'b1, {W{1'b0}}};
`endif
    endcase
    return r;
  endfunction

  // Rotate requests so bit 0 is the current priority holder, then take the first set bit.
  assign req_dbl = {req, req};
  assign rot     = req_dbl[ptr +: NREQ];

  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pick  = mod_add(ptr, IDW'(i));
      end
    end
  end

  always_comb begin
    op_w = '0;
    a_w  = '0;
    b_w  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        op_w = op_sel[2*i +: 2];
        a_w  = a_in[W*i +: W];
        b_w  = b_in[W*i +: W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load_win  = 1'b0;
    case (state)
      IDLE: if (found) begin
        state_nxt = GRANT;
        load_win  = 1'b1;
      end
      GRANT: state_nxt = EXEC;
      EXEC:  state_nxt = RESP;
      RESP: if (res_ready) begin
        if (found) begin
          state_nxt = GRANT;
          load_win  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= load_win ? (NREQ'(1) << pick) : '0;
      if (load_win) begin
        win <= pick;
        ptr <= mod_add(pick, IDW'(1));
      end
    end
  end

  // Stage p0: operands of the granted requester captured at the end of GRANT.
  always_ff @(posedge clk) begin
    if (state == GRANT) begin
      op_p0 <= op_w;
      a_p0  <= a_w;
      b_p0  <= b_w;
    end
  end

  assign gate_res = gate_eval(op_p0, a_p0, b_p0);

  // Result stage: written in EXEC, held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_err  <= 1'b0;
      res_id   <= '0;
    end else if (state == EXEC) begin
      res_data <= gate_res[W-1:0];
      res_err  <= gate_res[W];
      res_id   <= win;
    end
  end

  assign busy      = (state != IDLE);
  assign res_valid = (state == RESP);

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Scoreboard bench for gate_op_arbiter (NREQ=4, W=4); expectations follow GATE_ARB_XOR_EN.
module tb_gate_op_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op_sel;
  logic [W*NREQ-1:0] a_in, b_in;
  logic [NREQ-1:0]   gnt;
  logic              busy, res_valid, res_ready, res_err;
  logic [W-1:0]      res_data;
  logic [IDW-1:0]    res_id;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  logic [3:0] exp_gnt[$];
  logic [6:0] exp_res[$];   // {err, id, data}

`ifdef GATE_ARB_XOR_EN
  localparam logic       XE   = 1'b0;
  localparam logic [3:0] R2_D = 4'b0110;
  localparam logic [3:0] R3_D = 4'b1001;
`else
  localparam logic       XE   = 1'b1;
  localparam logic [3:0] R2_D = 4'b0000;
  localparam logic [3:0] R3_D = 4'b0000;
`endif

  gate_op_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_sel(op_sel), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_err(res_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare grants and accepted results against the queues.
  always @(negedge clk) begin
    logic [3:0] eg;
    logic [6:0] er;
    if (rst_n === 1'b1) begin
      if (gnt != 0) begin
        if (exp_gnt.size() == 0) check("gnt_unexpected", gnt, 0);
        else begin
          eg = exp_gnt.pop_front();
          check("gnt", gnt, eg);
        end
      end
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) check("res_unexpected", 1, 0);
        else begin
          er = exp_res.pop_front();
          check("res_data", res_data, er[3:0]);
          check("res_id", res_id, er[5:4]);
          check("res_err", res_err, er[6]);
        end
      end
    end
  end

  task automatic set_fields(input int id, input logic [1:0] op, input logic [3:0] a,
                            input logic [3:0] b);
    op_sel[2*id +: 2] = op;
    a_in[W*id +: W]   = a;
    b_in[W*id +: W]   = b;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 20);
    check("idle_timeout", busy, 0);
  endtask

  task automatic do_txn(input int id, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input bit drop_in_grant,
                        input logic [3:0] ed, input logic ee);
    int n;
    exp_gnt.push_back(4'b0001 << id);
    exp_res.push_back({ee, 2'(id), ed});
    @(posedge clk); #1;
    set_fields(id, op, a, b);
    req[id] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 0 && n < 12);
    check("gnt_latency", n, 2);
    if (drop_in_grant) req[id] = 1'b0;
    else begin @(posedge clk); #1; req[id] = 1'b0; end
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    check("valid_latency", n, 4);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    int gc[5];
    rst_n = 1'b0; req = '0; op_sel = '0; a_in = '0; b_in = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_id", res_id, 0);
    check("rst_err", res_err, 0);
    res_ready = 1'b1;

    // AND then OR on requester 0
    do_txn(0, 2'b00, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0);
    do_txn(0, 2'b01, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0);

    // Reset while a result is pending
    res_ready = 1'b0;
    exp_gnt.push_back(4'b1000);
    @(posedge clk); #1;
    set_fields(3, 2'b01, 4'b1111, 4'b0000);
    req[3] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 0 && n < 12);
    req[3] = 1'b0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    check("pre_rst_valid", res_valid, 1);
    check("pre_rst_data", res_data, 4'b1111);
    check("pre_rst_id", res_id, 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", res_valid, 0);
    check("arst_data", res_data, 0);
    check("arst_id", res_id, 0);
    check("arst_busy", busy, 0);
    check("arst_gnt", gnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_busy", busy, 0);
    end
    res_ready = 1'b1;

    // All four requesting: round-robin with wrap, one grant every 3 cycles
    exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0010); exp_gnt.push_back(4'b0100);
    exp_gnt.push_back(4'b1000); exp_gnt.push_back(4'b0001);
    exp_res.push_back({1'b0, 2'd0, 4'b1000});
    exp_res.push_back({1'b0, 2'd1, 4'b0111});
    exp_res.push_back({XE,   2'd2, R2_D});
    exp_res.push_back({XE,   2'd3, R3_D});
    exp_res.push_back({1'b0, 2'd0, 4'b1000});
    @(posedge clk); #1;
    set_fields(0, 2'b00, 4'b1100, 4'b1010);
    set_fields(1, 2'b01, 4'b0101, 4'b0010);
    set_fields(2, 2'b10, 4'b1100, 4'b1010);
    set_fields(3, 2'b11, 4'b1100, 4'b1010);
    req = 4'b1111;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 5; i++) begin
      @(negedge clk);
      if (gnt != 0) begin
        gc[cnt] = cyc;
        cnt++;
        if (cnt == 5) req = '0;
      end
    end
    req = '0;
    check("rr_grant_count", cnt, 5);
    for (int i = 0; i < 4; i++) check("rr_interval", gc[i+1] - gc[i], 3);
    wait_idle();

    // Consumer stalls for 5 cycles while another requester waits
    res_ready = 1'b0;
    exp_gnt.push_back(4'b0100);
    exp_res.push_back({1'b0, 2'd2, 4'b0111});
    @(posedge clk); #1;
    set_fields(2, 2'b01, 4'b0011, 4'b0100);
    req[2] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 0 && n < 12);
    @(posedge clk); #1;
    req[2] = 1'b0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    exp_gnt.push_back(4'b0010);
    exp_res.push_back({1'b0, 2'd1, 4'b0110});
    set_fields(1, 2'b00, 4'b1111, 4'b0110);
    req[1] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", res_valid, 1);
      check("stall_data", res_data, 4'b0111);
      check("stall_id", res_id, 2);
      check("stall_gnt", gnt, 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("gnt_after_ready", gnt, 4'b0010);
    req[1] = 1'b0;
    wait_idle();

    // Opcode 10 on a=b=1
    do_txn(0, 2'b10, 4'b0001, 4'b0001, 1'b0, 4'b0000, XE);

    // Wide OR with req dropped during GRANT
    do_txn(2, 2'b01, 4'b1100, 4'b1010, 1'b1, 4'b1110, 1'b0);

    repeat (3) @(negedge clk);
    check("res_queue_drained", exp_res.size(), 0);
    check("gnt_queue_drained", exp_gnt.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
